// File: rtl/cpu_ctrl_fsm_if.sv
// Data-memory bus handshake between the CPU control FSM and the bus arbiter.
interface cpu_ctrl_fsm_if;
  logic bus_req;
  logic bus_grant;
  logic data_mem_wr;
  logic data_mem_rd;
  logic bus_err;

  modport master (
    output bus_req,
    output data_mem_wr,
    output data_mem_rd,
    output bus_err,
    input  bus_grant
  );

  modport slave (
    input  bus_req,
    input  data_mem_wr,
    input  data_mem_rd,
    input  bus_err,
    output bus_grant
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// CPU control sequencer: fetch/decode/execute, bus wait with timeout,
// prioritised interrupt entry and a single-step debug break state.
module cpu_ctrl_fsm #(
  parameter int unsigned IRQ_NUM     = 4,
  parameter int unsigned BUS_TIMEOUT = 15,
  parameter logic [7:0]  VEC_BASE    = 8'h10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               addr_op2_sel,
  input  logic [3:0]         opcode,
  input  logic [3:0]         ctrl_op,
  output logic               initialize,
  output logic               fetch,
  output logic               decode,
  output logic               interrupt,
  output logic               ex_jump,
  output logic               ex_call,
  output logic               ex_ret_sub,
  output logic               ex_ret_int,
  output logic               wr_data_sel,
  output logic               reg_wr_en,
  output logic [1:0]         alu_op_type,
  input  logic               alu_flag_z,
  input  logic               alu_flag_c,
  input  logic               alu_flag_n,
  input  logic               alu_flag_v,
  cpu_ctrl_fsm_if.master     bus,
  input  logic [IRQ_NUM-1:0] irq,
  output logic [IRQ_NUM-1:0] irq_ack,
  output logic [7:0]         irq_vec,
  input  logic               flag_ie_din,
  input  logic               flag_if_din,
  output logic               flag_ie,
  output logic               flag_if,
  input  logic               dbg_break,
  input  logic               dbg_continue,
  input  logic               dbg_step,
  input  logic               dbg_ie_wr,
  input  logic               dbg_ie_din,
  input  logic               dbg_reg_wr,
  input  logic               dbg_mem_wr,
  input  logic               dbg_mem_rd,
  output logic               dbg_is_brk
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EX_LD, S_EX_ST, S_EX_MOV, S_EX_ARITH,
    S_EX_LOGIC, S_EX_SHIFT, S_EX_CTRL, S_EX_NOP, S_INT_REQ, S_BREAK
  } state_e;

  // Compare-type opcodes sit at opcode[3]=1 so that bit suppresses writeback.
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHIFT = 4'h7,
    OP_CMP = 4'h8, OP_CMC = 4'h9, OP_TST = 4'hA, OP_LD  = 4'hB,
    OP_ST  = 4'hC, OP_MOV = 4'hD, OP_CTRL = 4'hE, OP_NOP = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    CO_JMP = 4'h0, CO_JZ  = 4'h1, CO_JNZ = 4'h2, CO_JC  = 4'h3,
    CO_JNC = 4'h4, CO_JN  = 4'h5, CO_JNN = 4'h6, CO_JV  = 4'h7,
    CO_JNV = 4'h8, CO_JSR = 4'h9, CO_RTS = 4'hA, CO_RTI = 4'hB,
    CO_STI = 4'hC, CO_CLI = 4'hD
  } ctrl_op_e;

  typedef enum logic [1:0] {
    ALU_MOVE, ALU_ARITH, ALU_LOGIC, ALU_SHIFT
  } alu_e;

  localparam logic [7:0] TMO    = 8'(BUS_TIMEOUT);
  localparam bit         TMO_EN = (BUS_TIMEOUT != 0);

  state_e     state_q, state_d;
  logic       step_q, step_d;
  logic [7:0] wait_q, wait_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] vec_q, vec_d;
  logic       ie_q, ie_d;
  logic       if_q, if_d;

  logic       ld_st, timeout, exec_done, go_int, in_ctrl;
  logic       irq_hit;
  logic [2:0] win_idx;
  logic       mem_wr, mem_rd;
  alu_e       alu_type;

  always_comb begin
    irq_hit = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < IRQ_NUM; i++) begin
      if (irq[i] && !irq_hit) begin
        win_idx = 3'(i);
        irq_hit = 1'b1;
      end
    end
  end

  always_comb begin
    ld_st   = (state_q == S_EX_LD) || (state_q == S_EX_ST);
    // Grant wins over a coinciding timeout.
    timeout = TMO_EN && ld_st && !bus.bus_grant && (wait_q == TMO);
    in_ctrl = (state_q == S_EX_CTRL);

    case (state_q)
      S_EX_MOV, S_EX_ARITH, S_EX_LOGIC, S_EX_SHIFT, S_EX_CTRL, S_EX_NOP:
        exec_done = 1'b1;
      S_EX_LD, S_EX_ST:
        exec_done = bus.bus_grant || timeout;
      default:
        exec_done = 1'b0;
    endcase
    go_int = exec_done && ie_q && irq_hit;

    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = (dbg_break || step_q) ? S_BREAK : S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LD:  state_d = S_EX_LD;
          OP_ST:  state_d = S_EX_ST;
          OP_MOV: state_d = S_EX_MOV;
          OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP, OP_CMC:
                  state_d = S_EX_ARITH;
          OP_AND, OP_OR, OP_XOR, OP_TST:
                  state_d = S_EX_LOGIC;
          OP_SHIFT: state_d = addr_op2_sel ? S_EX_SHIFT : S_EX_LOGIC;
          OP_CTRL:  state_d = S_EX_CTRL;
          default:  state_d = S_EX_NOP;
        endcase
      end
      S_EX_LD, S_EX_ST, S_EX_MOV, S_EX_ARITH, S_EX_LOGIC, S_EX_SHIFT,
      S_EX_CTRL, S_EX_NOP: begin
        if (exec_done) state_d = go_int ? S_INT_REQ : S_FETCH;
      end
      S_INT_REQ: state_d = S_FETCH;
      S_BREAK: begin
        if (dbg_continue) begin
          state_d = S_DECODE;
          step_d  = 1'b0;
        end else if (dbg_step) begin
          state_d = S_DECODE;
          step_d  = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Clearing whenever outside LD/ST is equivalent to clearing on entry.
    wait_d = wait_q;
    if (!ld_st)                 wait_d = '0;
    else if (!bus.bus_grant)    wait_d = wait_q + 8'd1;

    idx_d = idx_q;
    vec_d = vec_q;
    if (go_int) begin
      idx_d = win_idx;
      vec_d = VEC_BASE + {5'b0, win_idx};
    end

    ie_d = ie_q;
    if ((state_q == S_INIT) || (state_q == S_INT_REQ) ||
        (in_ctrl && ctrl_op == CO_CLI))                  ie_d = 1'b0;
    else if (in_ctrl && ctrl_op == CO_STI)               ie_d = 1'b1;
    else if (in_ctrl && ctrl_op == CO_RTI)               ie_d = flag_ie_din;
    else if (state_q == S_BREAK && dbg_ie_wr)            ie_d = dbg_ie_din;

    if_d = if_q;
    if (state_q == S_INIT)                               if_d = 1'b0;
    else if (state_q == S_INT_REQ)                       if_d = 1'b1;
    else if (in_ctrl && ctrl_op == CO_RTI)               if_d = flag_if_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      step_q  <= 1'b0;
      wait_q  <= '0;
      idx_q   <= '0;
      vec_q   <= VEC_BASE;
      ie_q    <= 1'b0;
      if_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      ie_q    <= ie_d;
      if_q    <= if_d;
    end
  end

  always_comb begin
    initialize = (state_q == S_INIT);
    decode     = (state_q == S_DECODE);
    interrupt  = (state_q == S_INT_REQ);
    dbg_is_brk = (state_q == S_BREAK);

    case (state_q)
      S_FETCH: fetch = !dbg_break && !step_q;
      S_BREAK: fetch = dbg_continue || dbg_step;
      default: fetch = 1'b0;
    endcase

    ex_jump = 1'b0;
    if (in_ctrl) begin
      case (ctrl_op)
        CO_JMP:  ex_jump = 1'b1;
        CO_JZ:   ex_jump = alu_flag_z;
        CO_JNZ:  ex_jump = !alu_flag_z;
        CO_JC:   ex_jump = alu_flag_c;
        CO_JNC:  ex_jump = !alu_flag_c;
        CO_JN:   ex_jump = alu_flag_n;
        CO_JNN:  ex_jump = !alu_flag_n;
        CO_JV:   ex_jump = alu_flag_v;
        CO_JNV:  ex_jump = !alu_flag_v;
        default: ex_jump = 1'b0;
      endcase
    end
    ex_call    = in_ctrl && (ctrl_op == CO_JSR);
    ex_ret_sub = in_ctrl && (ctrl_op == CO_RTS);
    ex_ret_int = in_ctrl && (ctrl_op == CO_RTI);

    case (state_q)
      S_EX_LD:                 reg_wr_en = bus.bus_grant;
      S_EX_MOV, S_EX_SHIFT:    reg_wr_en = 1'b1;
      S_EX_ARITH, S_EX_LOGIC:  reg_wr_en = !opcode[3];
      S_BREAK:                 reg_wr_en = dbg_reg_wr;
      default:                 reg_wr_en = 1'b0;
    endcase
    wr_data_sel = (state_q == S_EX_LD);

    case (state_q)
      S_EX_ARITH: alu_type = ALU_ARITH;
      S_EX_LOGIC: alu_type = ALU_LOGIC;
      S_EX_SHIFT: alu_type = ALU_SHIFT;
      default:    alu_type = ALU_MOVE;
    endcase
    alu_op_type = alu_type;

    if (state_q == S_BREAK) begin
      mem_wr = dbg_mem_wr;
      mem_rd = dbg_mem_rd;
    end else begin
      mem_wr = (state_q == S_EX_ST);
      mem_rd = (state_q == S_EX_LD);
    end

    irq_ack = interrupt ? (IRQ_NUM'(1) << idx_q) : '0;
  end

  assign irq_vec         = vec_q;
  assign flag_ie         = ie_q;
  assign flag_if         = if_q;
  assign bus.data_mem_wr = mem_wr;
  assign bus.data_mem_rd = mem_rd;
  assign bus.bus_req     = mem_wr | mem_rd;
  assign bus.bus_err     = timeout;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: instruction flow, interrupts, bus timeout, debug stepping.
module tb_cpu_ctrl_fsm;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SHIFT = 4'h7, OP_CMP = 4'h8,
                         OP_LD = 4'hB, OP_ST = 4'hC, OP_MOV = 4'hD, OP_CTRL = 4'hE;
  localparam logic [3:0] CO_JNZ = 4'h2, CO_STI = 4'hC;

  logic clk = 1'b0, rst;
  logic addr_op2_sel;
  logic [3:0] opcode, ctrl_op;
  logic initialize, fetch, decode, interrupt;
  logic ex_jump, ex_call, ex_ret_sub, ex_ret_int;
  logic wr_data_sel, reg_wr_en;
  logic [1:0] alu_op_type;
  logic alu_flag_z, alu_flag_c, alu_flag_n, alu_flag_v;
  logic [3:0] irq, irq_ack;
  logic [7:0] irq_vec;
  logic flag_ie_din, flag_if_din, flag_ie, flag_if;
  logic dbg_break, dbg_continue, dbg_step, dbg_ie_wr, dbg_ie_din;
  logic dbg_reg_wr, dbg_mem_wr, dbg_mem_rd, dbg_is_brk;
  int tests = 0;
  int fails = 0;

  cpu_ctrl_fsm_if bus_if ();

  cpu_ctrl_fsm #(.IRQ_NUM(4), .BUS_TIMEOUT(3), .VEC_BASE(8'h10)) dut (
    .clk(clk), .rst(rst), .addr_op2_sel(addr_op2_sel), .opcode(opcode), .ctrl_op(ctrl_op),
    .initialize(initialize), .fetch(fetch), .decode(decode), .interrupt(interrupt),
    .ex_jump(ex_jump), .ex_call(ex_call), .ex_ret_sub(ex_ret_sub), .ex_ret_int(ex_ret_int),
    .wr_data_sel(wr_data_sel), .reg_wr_en(reg_wr_en), .alu_op_type(alu_op_type),
    .alu_flag_z(alu_flag_z), .alu_flag_c(alu_flag_c), .alu_flag_n(alu_flag_n),
    .alu_flag_v(alu_flag_v), .bus(bus_if.master), .irq(irq), .irq_ack(irq_ack),
    .irq_vec(irq_vec), .flag_ie_din(flag_ie_din), .flag_if_din(flag_if_din),
    .flag_ie(flag_ie), .flag_if(flag_if), .dbg_break(dbg_break),
    .dbg_continue(dbg_continue), .dbg_step(dbg_step), .dbg_ie_wr(dbg_ie_wr),
    .dbg_ie_din(dbg_ie_din), .dbg_reg_wr(dbg_reg_wr), .dbg_mem_wr(dbg_mem_wr),
    .dbg_mem_rd(dbg_mem_rd), .dbg_is_brk(dbg_is_brk)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; addr_op2_sel = 1'b0; opcode = OP_MOV; ctrl_op = 4'h0;
    {alu_flag_z, alu_flag_c, alu_flag_n, alu_flag_v} = '0;
    irq = '0; flag_ie_din = 1'b0; flag_if_din = 1'b0;
    {dbg_break, dbg_continue, dbg_step, dbg_ie_wr, dbg_ie_din} = '0;
    {dbg_reg_wr, dbg_mem_wr, dbg_mem_rd} = '0;
    bus_if.bus_grant = 1'b0;
    tick(); tick();
    chk("rst_init", initialize, 1'b1);
    chk("rst_vec", irq_vec, 8'h10);
    chk("rst_bus_req", bus_if.bus_req, 1'b0);

    // MOV after reset release
    rst = 1'b1; #1;
    chk("mov_init", initialize, 1'b1);
    tick();
    chk("mov_fetch", fetch, 1'b1);
    chk("mov_fetch_we", reg_wr_en, 1'b0);
    chk("mov_ie_clr", flag_ie, 1'b0);
    chk("mov_if_clr", flag_if, 1'b0);
    tick();
    chk("mov_decode", decode, 1'b1);
    chk("mov_decode_we", reg_wr_en, 1'b0);
    tick();
    chk("mov_ex_we", reg_wr_en, 1'b1);
    chk("mov_ex_alu", alu_op_type, 2'd0);
    chk("mov_ex_wds", wr_data_sel, 1'b0);
    tick();
    chk("mov_back_fetch", fetch, 1'b1);
    chk("mov_back_we", reg_wr_en, 1'b0);

    // STI enables interrupts
    opcode = OP_CTRL; ctrl_op = CO_STI;
    tick(); tick();
    chk("sti_jump", ex_jump, 1'b0);
    tick();
    chk("sti_ie", flag_ie, 1'b1);

    // ADD with irq pending -> INT_REQ, index 1
    opcode = OP_ADD; irq = 4'b1010;
    tick(); tick();
    chk("add_alu", alu_op_type, 2'd1);
    chk("add_we", reg_wr_en, 1'b1);
    chk("add_ack_idle", irq_ack, 4'b0000);
    tick();
    chk("int_state", interrupt, 1'b1);
    chk("int_ack", irq_ack, 4'b0010);
    chk("int_vec", irq_vec, 8'h11);
    tick();
    chk("int_fetch", fetch, 1'b1);
    chk("int_if", flag_if, 1'b1);
    chk("int_ie", flag_ie, 1'b0);
    chk("int_ack_gone", irq_ack, 4'b0000);
    chk("int_vec_hold", irq_vec, 8'h11);

    // CMP: no writeback, interrupts masked
    opcode = OP_CMP;
    tick(); tick();
    chk("cmp_we", reg_wr_en, 1'b0);
    chk("cmp_alu", alu_op_type, 2'd1);
    tick();
    chk("cmp_no_int", interrupt, 1'b0);
    chk("cmp_fetch", fetch, 1'b1);
    irq = '0;

    // JNZ taken / not taken
    opcode = OP_CTRL; ctrl_op = CO_JNZ; alu_flag_z = 1'b0;
    tick(); tick();
    chk("jnz_taken", ex_jump, 1'b1);
    tick();
    alu_flag_z = 1'b1;
    tick(); tick();
    chk("jnz_not_taken", ex_jump, 1'b0);
    tick();
    alu_flag_z = 1'b0;

    // SHIFT routing by addr_op2_sel
    opcode = OP_SHIFT; addr_op2_sel = 1'b1;
    tick(); tick();
    chk("shift_alu", alu_op_type, 2'd3);
    chk("shift_we", reg_wr_en, 1'b1);
    tick();
    addr_op2_sel = 1'b0;
    tick(); tick();
    chk("shift_as_logic", alu_op_type, 2'd2);
    tick();

    // LD timeout after 4 cycles without grant
    opcode = OP_LD;
    tick(); tick();
    chk("ld1_rd", bus_if.data_mem_rd, 1'b1);
    chk("ld1_req", bus_if.bus_req, 1'b1);
    chk("ld1_wds", wr_data_sel, 1'b1);
    chk("ld1_err", bus_if.bus_err, 1'b0);
    tick(); tick();
    chk("ld3_err", bus_if.bus_err, 1'b0);
    tick();
    chk("ld4_err", bus_if.bus_err, 1'b1);
    chk("ld4_we", reg_wr_en, 1'b0);
    tick();
    chk("ldto_fetch", fetch, 1'b1);
    chk("ldto_req", bus_if.bus_req, 1'b0);
    chk("ldto_err", bus_if.bus_err, 1'b0);

    // LD grant coinciding with timeout
    tick(); tick(); tick(); tick(); tick();
    bus_if.bus_grant = 1'b1; #1;
    chk("ldg_err", bus_if.bus_err, 1'b0);
    chk("ldg_we", reg_wr_en, 1'b1);
    chk("ldg_wds", wr_data_sel, 1'b1);
    tick();
    bus_if.bus_grant = 1'b0; #1;
    chk("ldg_fetch", fetch, 1'b1);

    // ST with immediate grant
    opcode = OP_ST;
    tick(); tick();
    bus_if.bus_grant = 1'b1; #1;
    chk("st_wr", bus_if.data_mem_wr, 1'b1);
    chk("st_we", reg_wr_en, 1'b0);
    tick();
    bus_if.bus_grant = 1'b0; #1;
    chk("st_fetch", fetch, 1'b1);

    // Reset during bus wait
    opcode = OP_LD;
    tick(); tick(); tick();
    chk("rstw_req_before", bus_if.bus_req, 1'b1);
    rst = 1'b0; #1;
    chk("rstw_req", bus_if.bus_req, 1'b0);
    chk("rstw_err", bus_if.bus_err, 1'b0);
    chk("rstw_init", initialize, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("rstw_if", flag_if, 1'b0);
    chk("rstw_fetch", fetch, 1'b1);

    // Debug break, register/memory access, single step, continue
    dbg_break = 1'b1; #1;
    chk("brk_fetch", fetch, 1'b0);
    tick();
    dbg_break = 1'b0;
    chk("brk_state", dbg_is_brk, 1'b1);
    dbg_reg_wr = 1'b1; dbg_mem_rd = 1'b1; dbg_ie_wr = 1'b1; dbg_ie_din = 1'b1; #1;
    chk("brk_we", reg_wr_en, 1'b1);
    chk("brk_rd", bus_if.data_mem_rd, 1'b1);
    chk("brk_req", bus_if.bus_req, 1'b1);
    tick();
    {dbg_reg_wr, dbg_mem_rd, dbg_ie_wr, dbg_ie_din} = '0;
    chk("brk_ie_wr", flag_ie, 1'b1);
    chk("brk_stay", dbg_is_brk, 1'b1);
    opcode = OP_MOV; dbg_step = 1'b1; #1;
    chk("step_fetch", fetch, 1'b1);
    tick();
    dbg_step = 1'b0;
    chk("step_decode", decode, 1'b1);
    tick();
    chk("step_ex_we", reg_wr_en, 1'b1);
    tick();
    chk("step_fetch_blocked", fetch, 1'b0);
    tick();
    chk("step_rebreak", dbg_is_brk, 1'b1);
    tick();
    chk("step_hold", dbg_is_brk, 1'b1);
    dbg_continue = 1'b1; dbg_step = 1'b1;
    tick();
    dbg_continue = 1'b0; dbg_step = 1'b0;
    chk("cont_decode", decode, 1'b1);
    tick(); tick();
    chk("cont_fetch", fetch, 1'b1);
    tick();
    chk("cont_free", decode, 1'b1);
    chk("cont_nobrk", dbg_is_brk, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 Parameter IRQ_NUM, default 4: number of interrupt request lines, legal range 1..8.
REQ-002 Parameter BUS_TIMEOUT, default 15: maximum number of cycles to wait for bus_grant, legal range 0..255; 0 disables the timeout.
REQ-003 Parameter VEC_BASE, default 8'h10: base address of the interrupt vector.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 addr_op2_sel, opcode[3:0], ctrl_op[3:0]  in  fetched-instruction fields.
REQ-007 initialize, fetch, decode, interrupt  out  1 each  processor phase strobes.
REQ-008 ex_jump, ex_call, ex_ret_sub, ex_ret_int  out  1 each  control-flow execute strobes.
REQ-009 wr_data_sel  out 1; reg_wr_en  out 1; alu_op_type  out 2  datapath controls.
REQ-010 alu_flag_z, alu_flag_c, alu_flag_n, alu_flag_v  in  1 each  ALU flags.
REQ-011 bus_req, data_mem_wr, data_mem_rd  out  1 each; bus_grant  in  1; bus_err  out  1  one-cycle pulse on bus timeout.
REQ-012 irq  in  IRQ_NUM  level-sensitive interrupt requests.
REQ-013 irq_ack  out  IRQ_NUM  one-hot interrupt acknowledge.
REQ-014 irq_vec  out  8  vector of the interrupt being serviced.
REQ-015 flag_ie_din, flag_if_din  in  1 each; flag_ie, flag_if  out  1 each  interrupt-enable and in-service flags.
REQ-016 dbg_break, dbg_continue, dbg_step, dbg_ie_wr, dbg_ie_din, dbg_reg_wr, dbg_mem_wr, dbg_mem_rd  in  1 each; dbg_is_brk  out  1  debug interface.

Function
REQ-017 States SHALL be INIT, FETCH, DECODE, EX_LD, EX_ST, EX_MOV, EX_ARITH, EX_LOGIC, EX_SHIFT, EX_CTRL, EX_NOP, INT_REQ and BREAK; an illegal state SHALL go to INIT.
REQ-018 INIT SHALL go to FETCH.
REQ-019 FETCH SHALL go to BREAK if dbg_break or step_pending is set, else to DECODE.
REQ-020 DECODE SHALL dispatch on opcode using the shared opcode definitions:
- LD→EX_LD, ST→EX_ST, MOV→EX_MOV.
- ADD/ADC/SUB/SBC/CMP/CMC→EX_ARITH.
- AND/OR/XOR/TST→EX_LOGIC.
- SHIFT→EX_SHIFT if addr_op2_sel, else EX_LOGIC.
- CTRL→EX_CTRL; any other opcode→EX_NOP.
REQ-021 An execute state SHALL complete in one cycle, except EX_LD/EX_ST, which complete on bus_grant or on timeout.
REQ-022 On completion, the FSM SHALL go to INT_REQ if flag_ie and |irq, else to FETCH.
REQ-023 A wait counter (8 bit) SHALL clear on entry to EX_LD/EX_ST and increment on each cycle without grant.
REQ-024 When BUS_TIMEOUT≠0 and the counter equals BUS_TIMEOUT with no grant:
- pulse bus_err for that cycle;
- hold reg_wr_en low;
- treat the instruction as complete.
REQ-025 If grant and timeout coincide, the grant SHALL win: no bus_err is raised.
REQ-026 Interrupt priority: the lowest-index asserted irq bit wins.
REQ-027 The winning index SHALL be registered on the transition into INT_REQ.
REQ-028 In INT_REQ, irq_ack SHALL be one-hot at the winning index for exactly one cycle; it SHALL be zero at all other times.
REQ-029 irq_vec SHALL equal VEC_BASE + index (8-bit wrap), SHALL be valid during INT_REQ, and SHALL hold until the next INT_REQ.
REQ-030 INT_REQ SHALL go to FETCH.
REQ-031 BREAK SHALL go to DECODE on dbg_continue (clearing step_pending) or on dbg_step (setting step_pending); dbg_continue has priority over dbg_step.
REQ-032 step_pending SHALL cause the next FETCH to enter BREAK; INT_REQ does not clear step_pending.
REQ-033 fetch SHALL be asserted as follows: in FETCH = ~dbg_break & ~step_pending; in BREAK = dbg_continue | dbg_step; 0 elsewhere.
REQ-034 decode, interrupt, initialize and dbg_is_brk SHALL be the state decodes of DECODE, INT_REQ, INIT and BREAK respectively.
REQ-035 ex_jump SHALL be driven only in EX_CTRL, by ctrl_op:
- JMP→1; JZ/JNZ→±z; JC/JNC→±c; JN/JNN→±n; JV/JNV→±v;
- any other ctrl_op→0.
REQ-036 ex_call, ex_ret_sub, ex_ret_int, STI and CLI SHALL be asserted in EX_CTRL for ctrl_op = JSR, RTS, RTI, STI and CLI respectively.
REQ-037 reg_wr_en SHALL be driven per state:
- EX_LD: bus_grant; EX_MOV/EX_SHIFT: 1;
- EX_ARITH/EX_LOGIC: ~opcode[3];
- BREAK: dbg_reg_wr; all other states: 0.
REQ-038 wr_data_sel SHALL equal (state==EX_LD).
REQ-039 alu_op_type SHALL be ARITH, LOGIC or SHIFT in the corresponding execute state, else MOVE.
REQ-040 In BREAK, data_mem_wr = dbg_mem_wr and data_mem_rd = dbg_mem_rd; in other states they decode EX_ST and EX_LD.
REQ-041 In EX_LD/EX_ST, data_mem_wr/rd SHALL drop in the cycle after a timeout.
REQ-042 bus_req SHALL equal data_mem_wr | data_mem_rd.
REQ-043 flag_ie SHALL be updated synchronously, first applicable condition wins:
- cleared on initialize, INT_REQ or CLI;
- else set on STI;
- else loaded from flag_ie_din on RTI;
- else loaded from dbg_ie_din in BREAK with dbg_ie_wr.
REQ-044 flag_if SHALL be updated synchronously, first applicable condition wins:
- cleared on initialize;
- else set in INT_REQ;
- else loaded from flag_if_din on RTI.

Reset
REQ-045 While rst=0 the FSM SHALL be in state INIT with step_pending=0, wait counter=0 and irq_vec=VEC_BASE.
REQ-046 Reset applied mid-bus-wait SHALL immediately deassert bus_req, with no bus_err pulse.
REQ-047 flag_ie and flag_if SHALL be cleared in the first cycle after release, via initialize.

Verification
REQ-048 After reset release with opcode=MOV: state sequence INIT, FETCH, DECODE, EX_MOV, FETCH; reg_wr_en=1 only in EX_MOV.
REQ-049 With IRQ_NUM=4, flag_ie=1 and irq=4'b1010 at the end of an ADD: INT_REQ with irq_ack=4'b0010, irq_vec=8'h11, flag_if=1, flag_ie=0.
REQ-050 With BUS_TIMEOUT=3 and bus_grant held 0 during LD: bus_err pulses in the 4th EX_LD cycle, reg_wr_en stays 0, then FETCH.
REQ-051 In an LD, grant arrives in the same cycle as the timeout: no bus_err, reg_wr_en=1, wr_data_sel=1.
REQ-052 From BREAK, a dbg_step pulse: exactly one instruction executes, then BREAK re-entered with dbg_is_brk=1; dbg_continue resumes free running.
REQ-053 With ctrl_op=JNZ, alu_flag_z=0: ex_jump=1 for the EX_CTRL cycle; with alu_flag_z=1: ex_jump=0.
